nn_calc_sequencer: RTL and testbench

Sequencer for the neural-network datapath: on a start request from the Avalon control register it walks the pixel and weight memories and computes ten dot products. Each is a 784-pixel × 784-weight multiply-accumulate. The ten results are written into the result register file, and the block reports completion and overflow back to the bus interface's status register. It sits between the Avalon slave (start_calc, clear_data, done_calc, overflow), the pixel/weight RAM read ports and the result registers.

---
 rtl/nn_calc_sequencer_pkg.sv | 10 +
 rtl/nn_mac_unit.sv | 60 ++++++
 rtl/nn_calc_sequencer.sv | 121 ++++++++++++
 tb/tb_nn_calc_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_calc_sequencer_pkg.sv
// nn_pkg: shared constants, FSM state encoding and accumulator type for the NN calc sequencer
package nn_pkg;
  localparam int NUM_OUT = 10;
  localparam int STEPS = 392;
  localparam int ACC_W = 32;
  localparam int PIX_WORDS = 196;
  localparam int WEIGHT_WORDS = 3920;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;
  typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: two 8x16 multiplies per step, registered product, saturating 32-bit accumulator
// with a sticky overflow flag.
module nn_mac_unit
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flush,
  input  logic        ovf_clr,
  input  logic        in_valid,
  input  logic        bank_sel,
  input  logic [15:0] pixel_rdata1,
  input  logic [15:0] pixel_rdata2,
  input  logic [31:0] weight_rdata,
  output acc_t        acc,
  output logic        overflow
);
  logic [15:0] pix;
  logic signed [25:0] prod_d, prod_q;
  logic signed [32:0] sum;
  logic pv_d, pv_q, ovf_d, ovf_q, sat;
  acc_t acc_d, acc_q;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= pv_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end

  always_comb begin
    pix = bank_sel ? pixel_rdata2 : pixel_rdata1;
    // Pixels are unsigned (zero-extended), weights signed; the 26-bit sum cannot wrap.
    prod_d = 26'($signed({1'b0, pix[7:0]})) * 26'($signed(weight_rdata[15:0]))
           + 26'($signed({1'b0, pix[15:8]})) * 26'($signed(weight_rdata[31:16]));
    pv_d = in_valid;
    sum = 33'(acc_q) + 33'(prod_q);
    sat = sum[32] ^ sum[31];
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (pv_q) begin
      acc_d = sat ? (sum[32] ? acc_t'(32'h8000_0000) : acc_t'(32'h7FFF_FFFF)) : acc_t'(sum[31:0]);
      ovf_d = ovf_q | sat;
    end
    if (flush) begin
      acc_d = '0;
      pv_d = 1'b0;
    end
    if (ovf_clr) ovf_d = 1'b0;
  end

  assign acc = acc_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/nn_calc_sequencer.sv
// nn_calc_sequencer: runs ten 784-term dot products over pixel/weight RAM into the result registers.
// Define NN_RELU_EN to clamp negative results to zero on write.
module nn_calc_sequencer
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_calc,
  input  logic        clear_data,
  output logic [9:0]  pixel_raddr,
  input  logic [15:0] pixel_rdata1,
  input  logic [15:0] pixel_rdata2,
  output logic [11:0] weight_raddr,
  input  logic [31:0] weight_rdata,
  output logic [3:0]  result_addr,
  output logic [31:0] result_wdata,
  output logic        result_we,
  output logic        done_calc,
  output logic        overflow,
  output logic        busy
);
  state_t state_d, state_q;
  logic [3:0] n_d, n_q;
  logic [8:0] s_d, s_q;
  logic drain_d, drain_q, start_d, start_q, vld_d, vld_q, sel_d, sel_q;
  logic start_edge, flush, ovf_clr;
  acc_t acc;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      s_q     <= '0;
      drain_q <= 1'b0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      s_q     <= s_d;
      drain_q <= drain_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
    end

  assign start_edge = start_calc & ~start_q;

  always_comb begin
    state_d = state_q;
    n_d = n_q;
    s_d = s_q;
    drain_d = drain_q;
    start_d = start_calc;
    vld_d = state_q == RUN;
    sel_d = s_q[0];
    flush = 1'b0;
    ovf_clr = 1'b0;
    case (state_q)
      IDLE, DONE: if (start_edge) begin
        state_d = RUN;
        n_d = '0;
        s_d = '0;
        flush = 1'b1;
        ovf_clr = 1'b1;
      end
      RUN: begin
        s_d = s_q == 9'(STEPS - 1) ? '0 : s_q + 9'd1;
        state_d = s_q == 9'(STEPS - 1) ? DRAIN : RUN;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        state_d = drain_q ? STORE : DRAIN;
      end
      STORE: begin
        flush = 1'b1;
        s_d = '0;
        state_d = n_q == 4'(NUM_OUT - 1) ? DONE : RUN;
        n_d = n_q == 4'(NUM_OUT - 1) ? n_q : n_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start edge in the same cycle.
    if (clear_data) begin
      state_d = IDLE;
      n_d = '0;
      s_d = '0;
      drain_d = 1'b0;
      vld_d = 1'b0;
      flush = 1'b1;
      ovf_clr = 1'b1;
    end
  end

  nn_mac_unit u_mac (
    .clk          (clk),
    .n_rst        (n_rst),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .in_valid     (vld_q),
    .bank_sel     (sel_q),
    .pixel_rdata1 (pixel_rdata1),
    .pixel_rdata2 (pixel_rdata2),
    .weight_rdata (weight_rdata),
    .acc          (acc),
    .overflow     (overflow)
  );

  assign pixel_raddr = {2'b00, s_q[8:1]};
  assign weight_raddr = 12'(n_q) * 12'(STEPS) + 12'(s_q);
  assign busy = state_q == RUN || state_q == DRAIN || state_q == STORE;
  assign result_we = state_q == STORE;
  assign done_calc = state_q == DONE;
  assign result_addr = result_we ? n_q : '0;
`ifdef NN_RELU_EN
  assign result_wdata = result_we && !acc[ACC_W-1] ? acc : '0;
`else
  assign result_wdata = result_we ? acc : '0;
`endif
endmodule

// File: tb/tb_nn_calc_sequencer.sv
// tb_nn_calc_sequencer: directed bench with synchronous RAM models and a result-write monitor.
module tb_nn_calc_sequencer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_calc = 1'b0;
  logic clear_data = 1'b0;
  logic [9:0] pixel_raddr;
  logic [15:0] pixel_rdata1, pixel_rdata2;
  logic [11:0] weight_raddr;
  logic [31:0] weight_rdata;
  logic [3:0] result_addr;
  logic [31:0] result_wdata;
  logic result_we, done_calc, overflow, busy;

  logic [7:0] pix [784];
  logic [15:0] wt [7840];
  logic [31:0] res [10];
  int cyc = 0;
  int t0 = 0;
  int we_cnt = 0;
  int we_bad = 0;
  int tests = 0;
  int fails = 0;

  nn_calc_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start_calc   (start_calc),
    .clear_data   (clear_data),
    .pixel_raddr  (pixel_raddr),
    .pixel_rdata1 (pixel_rdata1),
    .pixel_rdata2 (pixel_rdata2),
    .weight_raddr (weight_raddr),
    .weight_rdata (weight_rdata),
    .result_addr  (result_addr),
    .result_wdata (result_wdata),
    .result_we    (result_we),
    .done_calc    (done_calc),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank1 word w holds pixels 4w,4w+1; bank2 word w holds 4w+2,4w+3; weight word a holds weights 2a,2a+1.
  always @(posedge clk) begin
    pixel_rdata1 <= {pix[4*int'(pixel_raddr)+1], pix[4*int'(pixel_raddr)]};
    pixel_rdata2 <= {pix[4*int'(pixel_raddr)+3], pix[4*int'(pixel_raddr)+2]};
    weight_rdata <= {wt[2*int'(weight_raddr)+1], wt[2*int'(weight_raddr)]};
  end

  always @(negedge clk) if (result_we) begin
    if (result_addr < 4'd10) res[result_addr] = result_wdata;
    if (cyc - t0 != 395 * (we_cnt + 1) || result_addr != 4'(we_cnt)) we_bad++;
    we_cnt++;
  end

  task automatic start_edge();
    @(negedge clk) start_calc = 1'b0;
    @(negedge clk) start_calc = 1'b1;
    t0 = cyc;
    we_cnt = 0;
    we_bad = 0;
    for (int i = 0; i < 10; i++) res[i] = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(output int rel);
    rel = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_calc) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk) clear_data = 1'b1;
    @(negedge clk) clear_data = 1'b0;
  endtask

  task automatic check_run(input string name);
    int rel;
    wait_done(rel);
    tests++;
    if (rel !== 3951) begin fails++; $display("FAIL %s done cycle: got %0d want 3951", name, rel); end
    tests++;
    if (we_cnt !== 10 || we_bad !== 0) begin
      fails++; $display("FAIL %s writes: got %0d (bad %0d) want 10 (bad 0)", name, we_cnt, we_bad);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    tests++;
    if ({pixel_raddr, weight_raddr, result_addr, result_wdata, result_we, done_calc, overflow, busy} !== '0) begin
      fails++; $display("FAIL reset outputs: got nonzero busy=%b done=%b we=%b", busy, done_calc, result_we);
    end
    @(negedge clk) n_rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done_calc !== 1'b0) begin
      fails++; $display("FAIL reset idle: busy=%b done=%b want 0 0", busy, done_calc);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 784; k++) pix[k] = 8'd1;
    for (int i = 0; i < 7840; i++) wt[i] = 16'd1;
    start_edge();
    check_run("basic");
    for (int n = 0; n < 10; n++) begin
      tests++;
      if (res[n] !== 32'd784) begin fails++; $display("FAIL basic res[%0d]: got %0d want 784", n, res[n]); end
    end
    tests++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL basic flags: busy=%b ovf=%b want 0 0", busy, overflow);
    end
    do_clear();
    tests++;
    if (done_calc !== 1'b0) begin fails++; $display("FAIL basic clear: done=%b want 0", done_calc); end
  endtask

  task automatic test_indexing();
    for (int k = 0; k < 784; k++) pix[k] = 8'(k % 256);
    for (int n = 0; n < 10; n++) for (int k = 0; k < 784; k++) wt[n*784+k] = 16'(n + 1);
    start_edge();
    check_run("indexing");
    for (int n = 0; n < 10; n++) begin
      tests++;
      if (res[n] !== 32'((n + 1) * 98040)) begin
        fails++; $display("FAIL indexing res[%0d]: got %0d want %0d", n, res[n], (n + 1) * 98040);
      end
    end
    do_clear();
  endtask

  task automatic test_ordering();
    int exp;
    for (int k = 0; k < 784; k++) pix[k] = 8'((k * 7 + 3) % 256);
    for (int i = 0; i < 7840; i++) wt[i] = 16'((i * 37) % 201 - 100);
    start_edge();
    check_run("ordering");
    for (int n = 0; n < 10; n++) begin
      exp = 0;
      for (int k = 0; k < 784; k++) exp += int'(pix[k]) * int'($signed(wt[n*784+k]));
      tests++;
      if (res[n] !== 32'(exp)) begin
        fails++; $display("FAIL ordering res[%0d]: got %0d want %0d", n, $signed(res[n]), exp);
      end
    end
    do_clear();
  endtask

  task automatic test_overflow();
    logic [31:0] neg_exp;
    for (int k = 0; k < 784; k++) pix[k] = 8'd255;
    for (int i = 0; i < 7840; i++) wt[i] = 16'h7FFF;
    start_edge();
    repeat (100) @(negedge clk);
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf early: got %b want 0", overflow); end
    check_run("ovf_pos");
    tests++;
    if (res[0] !== 32'h7FFF_FFFF || res[9] !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_pos: res0=%h res9=%h ovf=%b want 7fffffff 7fffffff 1", res[0], res[9], overflow);
    end
    do_clear();
    tests++;
    if (overflow !== 1'b0 || done_calc !== 1'b0) begin
      fails++; $display("FAIL ovf clear: ovf=%b done=%b want 0 0", overflow, done_calc);
    end
    for (int i = 0; i < 7840; i++) wt[i] = 16'h8000;
`ifdef NN_RELU_EN
    neg_exp = 32'h0;
`else
    neg_exp = 32'h8000_0000;
`endif
    start_edge();
    check_run("ovf_neg");
    tests++;
    if (res[0] !== neg_exp || res[9] !== neg_exp || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_neg: res0=%h res9=%h ovf=%b want %h %h 1", res[0], res[9], overflow, neg_exp, neg_exp);
    end
    do_clear();
  endtask

  task automatic test_abort();
    for (int k = 0; k < 784; k++) pix[k] = 8'd1;
    for (int i = 0; i < 7840; i++) wt[i] = 16'd1;
    start_edge();
    repeat (1000) @(negedge clk);
    clear_data = 1'b1;
    @(negedge clk) clear_data = 1'b0;
    tests++;
    if (busy !== 1'b0 || done_calc !== 1'b0) begin
      fails++; $display("FAIL abort: busy=%b done=%b want 0 0", busy, done_calc);
    end
    repeat (500) @(negedge clk);
    tests++;
    if (we_cnt !== 2 || busy !== 1'b0) begin
      fails++; $display("FAIL abort writes: got %0d busy=%b want 2 0", we_cnt, busy);
    end
    start_edge();
    check_run("abort_rerun");
  endtask

  task automatic test_retrigger();
    int rel;
    repeat (50) @(negedge clk);
    tests++;
    if (done_calc !== 1'b1 || busy !== 1'b0 || we_cnt !== 10) begin
      fails++; $display("FAIL retrig level: done=%b busy=%b writes=%0d want 1 0 10", done_calc, busy, we_cnt);
    end
    start_edge();
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || done_calc !== 1'b0) begin
      fails++; $display("FAIL retrig restart: busy=%b done=%b want 1 0", busy, done_calc);
    end
    repeat (499) @(negedge clk) start_calc = 1'b0;
    @(negedge clk) start_calc = 1'b1;
    wait_done(rel);
    tests++;
    if (rel !== 3951 || we_cnt !== 10 || we_bad !== 0) begin
      fails++; $display("FAIL retrig busy edge: done at %0d writes %0d want 3951 10", rel, we_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    start_edge();
    repeat (2000) @(negedge clk);
    n_rst = 1'b0;
    start_calc = 1'b0;
    #1;
    tests++;
    if ({pixel_raddr, weight_raddr, result_addr, result_wdata, result_we, done_calc, overflow, busy} !== '0) begin
      fails++; $display("FAIL midrun reset outputs: busy=%b raddr=%0d waddr=%0d", busy, pixel_raddr, weight_raddr);
    end
    @(negedge clk) n_rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done_calc !== 1'b0 || we_cnt !== 5) begin
      fails++; $display("FAIL midrun reset idle: busy=%b done=%b writes=%0d want 0 0 5", busy, done_calc, we_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_indexing();
    test_ordering();
    test_overflow();
    test_abort();
    test_retrigger();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
